mem_access_ctrl: RTL and testbench

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

---
 rtl/mem_access_ctrl_pkg.sv | 63 ++++++
 rtl/mem_access_ctrl_load_align.sv | 24 ++
 rtl/mem_access_ctrl.sv | 134 +++++++++++++
 tb/tb_mem_access_ctrl.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_ctrl_pkg.sv
// Shared EXE->MEM types, memory-op encodings and decode helpers.
package mem_access_ctrl_pkg;

  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned BE_WIDTH   = DATA_WIDTH / 8;
  localparam int unsigned LANE_W     = $clog2(BE_WIDTH);

  typedef enum logic [3:0] {
    MEM_NONE = 4'd0,
    MEM_LB   = 4'd1,
    MEM_LH   = 4'd2,
    MEM_LW   = 4'd3,
    MEM_LBU  = 4'd4,
    MEM_LHU  = 4'd5,
    MEM_SB   = 4'd6,
    MEM_SH   = 4'd7,
    MEM_SW   = 4'd8
  } mem_ctrl_e;

  typedef struct packed {
    mem_ctrl_e             mem_ctrl;
    logic [4:0]            rd;
    logic [DATA_WIDTH-1:0] exe_out;
    logic [DATA_WIDTH-1:0] op3;
  } exe2mem_t;

  function automatic logic mem_is_load(input mem_ctrl_e c);
    return (c == MEM_LB) || (c == MEM_LH) || (c == MEM_LW) ||
           (c == MEM_LBU) || (c == MEM_LHU);
  endfunction

  function automatic logic mem_is_store(input mem_ctrl_e c);
    return (c == MEM_SB) || (c == MEM_SH) || (c == MEM_SW);
  endfunction

  // log2 of the access size in bytes
  function automatic logic [1:0] mem_size(input mem_ctrl_e c);
    case (c)
      MEM_LH, MEM_LHU, MEM_SH: return 2'd1;
      MEM_LW, MEM_SW:          return 2'd2;
      default:                 return 2'd0;
    endcase
  endfunction

  function automatic logic mem_misaligned(input mem_ctrl_e c, input logic [LANE_W-1:0] lane);
    case (mem_size(c))
      2'd1:    return lane[0];
      2'd2:    return lane != '0;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [BE_WIDTH-1:0] mem_be(input mem_ctrl_e c, input logic [LANE_W-1:0] lane);
    logic [BE_WIDTH-1:0] m;
    case (mem_size(c))
      2'd1:    m = BE_WIDTH'(2'b11);
      2'd2:    m = '1;
      default: m = BE_WIDTH'(1'b1);
    endcase
    return m << lane;
  endfunction

endpackage

// File: rtl/mem_access_ctrl_load_align.sv
// Extracts the addressed lane from load data and sign/zero-extends it.
module load_align
  import mem_access_ctrl_pkg::*;
(
  input  logic [DATA_WIDTH-1:0] rdata_i,
  input  logic [LANE_W-1:0]     lane_i,
  input  mem_ctrl_e             mem_ctrl_i,
  output logic [DATA_WIDTH-1:0] data_o
);

  logic [DATA_WIDTH-1:0] shifted;

  always_comb begin
    shifted = rdata_i >> {lane_i, 3'b000};
    case (mem_ctrl_i)
      MEM_LB:  data_o = {{(DATA_WIDTH-8){shifted[7]}}, shifted[7:0]};
      MEM_LBU: data_o = {{(DATA_WIDTH-8){1'b0}}, shifted[7:0]};
      MEM_LH:  data_o = {{(DATA_WIDTH-16){shifted[15]}}, shifted[15:0]};
      MEM_LHU: data_o = {{(DATA_WIDTH-16){1'b0}}, shifted[15:0]};
      default: data_o = shifted;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM stage: issues one data-memory access per EXE payload and hands the
// result to writeback; handles misalignment, timeout and flush.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int unsigned DMEM_TIMEOUT = 0
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  exe_valid_i,
  output logic                  exe_ready_o,
  input  exe2mem_t              exe2mem_i,
  input  logic                  flush_i,
  output logic                  dmem_req_o,
  output logic                  dmem_we_o,
  output logic [DATA_WIDTH-1:0] dmem_addr_o,
  output logic [DATA_WIDTH-1:0] dmem_wdata_o,
  output logic [BE_WIDTH-1:0]   dmem_be_o,
  input  logic                  dmem_gnt_i,
  input  logic                  dmem_rvalid_i,
  input  logic [DATA_WIDTH-1:0] dmem_rdata_i,
  output logic                  wb_valid_o,
  input  logic                  wb_ready_i,
  output exe2mem_t              wb_payload_o,
  output logic [DATA_WIDTH-1:0] wb_data_o,
  output logic                  wb_err_o
);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, DRAIN, HOLD} state_e;

  state_e                state_q, state_d;
  exe2mem_t              payload_q, payload_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  err_q, err_d;
  logic [31:0]           tmo_q, tmo_d;

  logic                  accept;
  logic                  timeout_hit;
  logic [LANE_W-1:0]     lane;
  logic [DATA_WIDTH-1:0] ld_data;

  assign lane        = payload_q.exe_out[LANE_W-1:0];
  assign exe_ready_o = !flush_i && ((state_q == IDLE) || ((state_q == HOLD) && wb_ready_i));
  assign accept      = exe_valid_i && exe_ready_o;
  assign timeout_hit = (DMEM_TIMEOUT != 0) && ((tmo_q + 32'd1) == DMEM_TIMEOUT);

  load_align u_load_align (
    .rdata_i    (dmem_rdata_i),
    .lane_i     (lane),
    .mem_ctrl_i (payload_q.mem_ctrl),
    .data_o     (ld_data)
  );

  always_comb begin
    state_d   = state_q;
    payload_d = payload_q;
    data_d    = data_q;
    err_d     = err_q;
    tmo_d     = tmo_q;

    case (state_q)
      REQ: begin
        if (flush_i)         state_d = dmem_gnt_i ? DRAIN : IDLE;
        else if (dmem_gnt_i) begin
          state_d = WAIT;
          tmo_d   = '0;
        end
      end
      WAIT: begin
        // A response coinciding with a flush is consumed here, so DRAIN never waits for it.
        if (dmem_rvalid_i) begin
          state_d = flush_i ? IDLE : HOLD;
          err_d   = 1'b0;
          data_d  = mem_is_load(payload_q.mem_ctrl) ? ld_data : payload_q.exe_out;
        end else if (flush_i) begin
          state_d = DRAIN;
        end else if (timeout_hit) begin
          state_d = HOLD;
          err_d   = 1'b1;
          data_d  = '0;
        end else begin
          tmo_d = tmo_q + 32'd1;
        end
      end
      DRAIN: if (dmem_rvalid_i) state_d = IDLE;
      HOLD:  if (flush_i || wb_ready_i) state_d = IDLE;
      default: ;
    endcase

    // Accept overrides the IDLE/HOLD exit so non-memory ops stream at one per cycle.
    if (accept) begin
      payload_d = exe2mem_i;
      err_d     = 1'b0;
      data_d    = exe2mem_i.exe_out;
      if (!mem_is_load(exe2mem_i.mem_ctrl) && !mem_is_store(exe2mem_i.mem_ctrl)) begin
        state_d = HOLD;
      end else if (mem_misaligned(exe2mem_i.mem_ctrl, exe2mem_i.exe_out[LANE_W-1:0])) begin
        state_d = HOLD;
        err_d   = 1'b1;
        data_d  = '0;
      end else begin
        state_d = REQ;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      payload_q <= '0;
      data_q    <= '0;
      err_q     <= 1'b0;
      tmo_q     <= '0;
    end else begin
      state_q   <= state_d;
      payload_q <= payload_d;
      data_q    <= data_d;
      err_q     <= err_d;
      tmo_q     <= tmo_d;
    end
  end

  assign dmem_req_o   = (state_q == REQ);
  assign dmem_we_o    = dmem_req_o && mem_is_store(payload_q.mem_ctrl);
  assign dmem_addr_o  = dmem_req_o ? {payload_q.exe_out[DATA_WIDTH-1:LANE_W], {LANE_W{1'b0}}} : '0;
  assign dmem_wdata_o = dmem_req_o ? (payload_q.op3 << {lane, 3'b000}) : '0;
  assign dmem_be_o    = dmem_req_o ? mem_be(payload_q.mem_ctrl, lane) : '0;

  assign wb_valid_o   = (state_q == HOLD);
  assign wb_payload_o = payload_q;
  assign wb_data_o    = data_q;
  assign wb_err_o     = err_q && wb_valid_o;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl; a second instance exercises the timeout.
module tb_mem_access_ctrl;
  import mem_access_ctrl_pkg::*;

  logic                  clk, rstn;
  logic                  exe_valid, flush, gnt, rvalid, wb_ready;
  exe2mem_t              pl;
  logic [DATA_WIDTH-1:0] rdata;

  logic                  exe_ready, req, we, wb_valid, wb_err;
  logic [DATA_WIDTH-1:0] addr, wdata, wb_data;
  logic [BE_WIDTH-1:0]   be;
  exe2mem_t              wb_pl;

  logic                  t_exe_ready, t_req, t_we, t_wb_valid, t_wb_err;
  logic [DATA_WIDTH-1:0] t_addr, t_wdata, t_wb_data;
  logic [BE_WIDTH-1:0]   t_be;
  exe2mem_t              t_wb_pl;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  mem_access_ctrl dut (
    .clk(clk), .rstn(rstn), .exe_valid_i(exe_valid), .exe_ready_o(exe_ready),
    .exe2mem_i(pl), .flush_i(flush), .dmem_req_o(req), .dmem_we_o(we),
    .dmem_addr_o(addr), .dmem_wdata_o(wdata), .dmem_be_o(be), .dmem_gnt_i(gnt),
    .dmem_rvalid_i(rvalid), .dmem_rdata_i(rdata), .wb_valid_o(wb_valid),
    .wb_ready_i(wb_ready), .wb_payload_o(wb_pl), .wb_data_o(wb_data), .wb_err_o(wb_err)
  );

  mem_access_ctrl #(.DMEM_TIMEOUT(4)) dut_t (
    .clk(clk), .rstn(rstn), .exe_valid_i(exe_valid), .exe_ready_o(t_exe_ready),
    .exe2mem_i(pl), .flush_i(flush), .dmem_req_o(t_req), .dmem_we_o(t_we),
    .dmem_addr_o(t_addr), .dmem_wdata_o(t_wdata), .dmem_be_o(t_be), .dmem_gnt_i(gnt),
    .dmem_rvalid_i(rvalid), .dmem_rdata_i(rdata), .wb_valid_o(t_wb_valid),
    .wb_ready_i(wb_ready), .wb_payload_o(t_wb_pl), .wb_data_o(t_wb_data), .wb_err_o(t_wb_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic set_op(input mem_ctrl_e c, input logic [31:0] a, input logic [31:0] d);
    pl.mem_ctrl = c;
    pl.rd       = 5'd3;
    pl.exe_out  = a;
    pl.op3      = d;
    exe_valid   = 1'b1;
  endtask

  initial begin
    rstn = 1'b0; exe_valid = 1'b0; flush = 1'b0; gnt = 1'b0; rvalid = 1'b0;
    wb_ready = 1'b0; rdata = '0; pl = '0;
    #12;
    check("rst_ready",   32'(exe_ready), 32'h1);
    check("rst_req",     32'(req), 32'h0);
    check("rst_wbvalid", 32'(wb_valid), 32'h0);
    check("rst_wbdata",  wb_data, 32'h0);
    check("rst_be",      32'(be), 32'h0);
    rstn = 1'b1;
    step();

    // back-to-back ALU ops
    wb_ready = 1'b1;
    set_op(MEM_NONE, 32'h1234, 32'h0);
    step();
    check("alu1_valid", 32'(wb_valid), 32'h1);
    check("alu1_data",  wb_data, 32'h1234);
    check("alu1_req",   32'(req), 32'h0);
    step();
    check("alu2_valid", 32'(wb_valid), 32'h1);
    check("alu2_data",  wb_data, 32'h1234);
    pl.exe_out = 32'h5678;
    step();
    check("alu3_valid", 32'(wb_valid), 32'h1);
    check("alu3_data",  wb_data, 32'h5678);
    check("alu3_req",   32'(req), 32'h0);
    exe_valid = 1'b0;
    step();
    check("alu_idle_valid", 32'(wb_valid), 32'h0);
    flush = 1'b1;
    #1;
    check("flush_ready", 32'(exe_ready), 32'h0);
    flush = 1'b0;

    // LB lane 3, grant after two cycles
    wb_ready = 1'b0;
    set_op(MEM_LB, 32'h1003, 32'h0);
    step();
    exe_valid = 1'b0;
    check("lb_req",  32'(req), 32'h1);
    check("lb_be",   32'(be), 32'h8);
    check("lb_addr", addr, 32'h1000);
    check("lb_we",   32'(we), 32'h0);
    step();
    check("lb_req_hold", 32'(req), 32'h1);
    step();
    check("lb_addr_hold", addr, 32'h1000);
    gnt = 1'b1;
    step();
    gnt = 1'b0;
    check("lb_wait_req",   32'(req), 32'h0);
    check("lb_wait_valid", 32'(wb_valid), 32'h0);
    rvalid = 1'b1; rdata = 32'h80FF_FFFF;
    step();
    rvalid = 1'b0; rdata = '0;
    check("lb_valid", 32'(wb_valid), 32'h1);
    check("lb_data",  wb_data, 32'hFFFF_FF80);
    check("lb_err",   32'(wb_err), 32'h0);
    check("lb_pl",    wb_pl.exe_out, 32'h1003);
    step();
    check("lb_hold_data", wb_data, 32'hFFFF_FF80);
    wb_ready = 1'b1;
    step();
    check("lb_done", 32'(wb_valid), 32'h0);

    // LHU lane 2, grant on first REQ cycle
    set_op(MEM_LHU, 32'h1002, 32'h0);
    step();
    exe_valid = 1'b0;
    gnt = 1'b1;
    step();
    gnt = 1'b0;
    rvalid = 1'b1; rdata = 32'h8001_1234;
    step();
    rvalid = 1'b0;
    check("lhu_data", wb_data, 32'h0000_8001);
    step();

    // aligned SW: store ack returns exe_out
    wb_ready = 1'b0;
    set_op(MEM_SW, 32'h4000, 32'hDEAD_BEEF);
    step();
    exe_valid = 1'b0;
    check("sw_we",    32'(we), 32'h1);
    check("sw_be",    32'(be), 32'hF);
    check("sw_wdata", wdata, 32'hDEAD_BEEF);
    gnt = 1'b1;
    step();
    gnt = 1'b0;
    rvalid = 1'b1; rdata = 32'h1111_1111;
    step();
    rvalid = 1'b0;
    check("sw_valid", 32'(wb_valid), 32'h1);
    check("sw_data",  wb_data, 32'h4000);
    wb_ready = 1'b1;
    step();

    // misaligned SW
    wb_ready = 1'b0;
    set_op(MEM_SW, 32'h2002, 32'h0);
    step();
    exe_valid = 1'b0;
    check("mis_req",   32'(req), 32'h0);
    check("mis_valid", 32'(wb_valid), 32'h1);
    check("mis_err",   32'(wb_err), 32'h1);
    wb_ready = 1'b1;
    step();
    wb_ready = 1'b0;

    // SH lane 2, flush in WAIT
    set_op(MEM_SH, 32'h2002, 32'hABCD);
    step();
    exe_valid = 1'b0;
    check("sh_be",    32'(be), 32'hC);
    check("sh_wdata", wdata, 32'hABCD_0000);
    check("sh_addr",  addr, 32'h2000);
    gnt = 1'b1;
    step();
    gnt = 1'b0;
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("drain_valid", 32'(wb_valid), 32'h0);
    check("drain_ready", 32'(exe_ready), 32'h0);
    step();
    check("drain_valid2", 32'(wb_valid), 32'h0);
    rvalid = 1'b1;
    step();
    rvalid = 1'b0;
    check("drain_done_valid", 32'(wb_valid), 32'h0);
    check("drain_done_ready", 32'(exe_ready), 32'h1);

    // timeout on the DMEM_TIMEOUT=4 instance
    set_op(MEM_LW, 32'h3000, 32'h0);
    step();
    exe_valid = 1'b0;
    gnt = 1'b1;
    step();
    gnt = 1'b0;
    step(); step(); step();
    check("tmo_wait_valid", 32'(t_wb_valid), 32'h0);
    step();
    check("tmo_valid",   32'(t_wb_valid), 32'h1);
    check("tmo_err",     32'(t_wb_err), 32'h1);
    check("tmo_data",    t_wb_data, 32'h0);
    check("notmo_valid", 32'(wb_valid), 32'h0);
    rstn = 1'b0;
    #3;
    rstn = 1'b1;
    step();

    // asynchronous reset while in REQ
    set_op(MEM_LW, 32'h5000, 32'h0);
    step();
    exe_valid = 1'b0;
    check("ar_pre_req", 32'(req), 32'h1);
    #2;
    rstn = 1'b0;
    #1;
    check("ar_req",   32'(req), 32'h0);
    check("ar_ready", 32'(exe_ready), 32'h1);
    check("ar_t_req", 32'(t_req), 32'h0);
    step();
    rstn = 1'b1;
    step();
    check("ar_after_req", 32'(req), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
